seq_ifq: RTL

SEQ_IFQ -- requirements
Module: seq_ifq

---
 rtl/seq_ifq_pkg.sv | 22 ++
 rtl/seq_ifq_fifo.sv | 68 ++++++
 rtl/seq_ifq.sv | 103 ++++++++++
 3 files changed

// File: rtl/seq_ifq_pkg.sv
// Shared sequencer definitions: the instruction word width, the opcode field and the opcode encodings.
// The core and the instruction queue both import these.
package seq_ifq_pkg;

   localparam int seq_in_width = 16;
   localparam int seq_op_width = 4;

   localparam logic [seq_op_width-1:0] seq_op_nop  = 4'h0;
   localparam logic [seq_op_width-1:0] seq_op_push = 4'h1;
   localparam logic [seq_op_width-1:0] seq_op_add  = 4'h2;
   localparam logic [seq_op_width-1:0] seq_op_send = 4'h3;

   function automatic logic [seq_op_width-1:0] inst_opcode(input logic [seq_in_width-1:0] inst);
      return inst[seq_in_width-1 -: seq_op_width];
   endfunction

   // Opcodes whose result lands in the register file a cycle later and so need a bubble.
   function automatic logic opcode_holds(input logic [seq_op_width-1:0] op);
      return (op == seq_op_push) || (op == seq_op_add);
   endfunction

endpackage

// File: rtl/seq_ifq_fifo.sv
// Instruction storage ring with read/write pointers and an occupancy count.
// Writes while full and reads while empty are ignored.
module seq_ifq_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       wr_en,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             empty_s;

   assign full_s  = (level_r == LW'(DEPTH));
   assign empty_s = (level_r == {LW{1'b0}});
   assign push_s  = wr_en & ~full_s;
   assign pop_s   = rd_en & ~empty_s;

   // Storage is left unreset; the level gates every read so stale words never escape.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign level   = level_r;
   assign full    = full_s;
   assign empty   = empty_s;

endmodule

// File: rtl/seq_ifq.sv
// Instruction queue in front of the sequencer core: buffers loader words and issues them,
// stalling sends on a busy transmitter and inserting a bubble after register-writing ops.
module seq_ifq
   import seq_ifq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [seq_in_width-1:0] i_wr_data,
   input  logic                    i_wr_valid,
   output logic                    o_wr_ready,
   output logic [seq_in_width-1:0] o_inst,
   output logic                    o_inst_valid,
   input  logic                    i_tx_busy,
   output logic [$clog2(DEPTH):0]  o_level
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [seq_in_width-1:0] hold_r;
   logic [seq_in_width-1:0] hold_s;
   logic [seq_in_width-1:0] head_s;
   logic [seq_in_width-1:0] inst_s;
   logic [seq_op_width-1:0] op_s;
   logic                    valid_s;
   logic                    pop_s;
   logic                    full_s;
   logic                    empty_s;
   logic [$clog2(DEPTH):0]  level_s;

   seq_ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (seq_in_width)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (i_wr_data),
      .wr_en   (i_wr_valid),
      .rd_en   (pop_s),
      .rd_data (head_s),
      .level   (level_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   assign op_s = inst_opcode(head_s);

   // Issue decision and next state: RUN issues the head, HOLD replays the latched word as a bubble.
   always_comb begin
      state_s = state_r;
      hold_s  = hold_r;
      inst_s  = {seq_in_width{1'b0}};
      valid_s = 1'b0;
      pop_s   = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (empty_s) begin
               inst_s = {seq_in_width{1'b0}};
            end else begin
               inst_s = head_s;
            end
            valid_s = ~empty_s & ~((op_s == seq_op_send) & i_tx_busy);
            pop_s   = valid_s;
            if (valid_s && opcode_holds(op_s)) begin
               state_s = ST_HOLD;
               hold_s  = head_s;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_HOLD: begin
            inst_s  = hold_r;
            state_s = ST_RUN;
         end
         default: begin
            state_s = ST_RUN;
         end
      endcase
   end

   // State and hold register; reset drops any pending held instruction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_RUN;
         hold_r  <= {seq_in_width{1'b0}};
      end else begin
         state_r <= state_s;
         hold_r  <= hold_s;
      end
   end

   assign o_inst       = inst_s;
   assign o_inst_valid = valid_s;
   assign o_wr_ready   = ~full_s;
   assign o_level      = level_s;

endmodule
